// File: rtl/period_meas_stage.sv
// Oscillator period meter: counts CLK cycles across 2^EDGE_DIV_BITS periods of an async
// input, strobes each completed measurement, and flags loss of oscillation by timeout.
module period_meas_stage #(
  parameter int OUT_BITS       = 28,
  parameter int EDGE_DIV_BITS  = 4,
  parameter int TIMEOUT_CYCLES = 2**27
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                FREQ_IN,
  output logic [OUT_BITS-1:0] OUT_VALUE,
  output logic                OUT_VALID,
  output logic                NO_SIGNAL
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [OUT_BITS-1:0] TMO    = OUT_BITS'(TIMEOUT_CYCLES);
  localparam logic [OUT_BITS-1:0] TMO_M1 = OUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                   state, state_n;
  logic                     s1, s2, s3;
  logic                     rise, boundary;
  logic [OUT_BITS-1:0]      acc, acc_n;
  logic [EDGE_DIV_BITS-1:0] edge_cnt, edge_cnt_n;
  logic [OUT_BITS-1:0]      value_n;
  logic                     valid_n, nosig_n;

  // Two-flop synchronizer plus a delay flop for edge detection; the fixed
  // latency shifts every edge equally and so drops out of the period.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= FREQ_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign boundary = rise && (edge_cnt == '1);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    edge_cnt_n = edge_cnt;
    value_n    = OUT_VALUE;
    valid_n    = 1'b0;
    nosig_n    = NO_SIGNAL;
    case (state)
      IDLE: begin
        acc_n      = '0;
        edge_cnt_n = '0;
        // Entry edge is treated as boundary 0, so the counter starts as if it
        // had just wrapped and the first window spans a full set of periods.
        if (EN && rise) state_n = MEASURE;
      end
      MEASURE: begin
        if (!EN) begin
          state_n    = IDLE;
          acc_n      = '0;
          edge_cnt_n = '0;
        end else begin
          acc_n = (acc == TMO) ? acc : acc + 1'b1;
          if (rise) edge_cnt_n = edge_cnt + 1'b1;
          if (boundary) begin
            value_n = acc + 1'b1;
            valid_n = 1'b1;
            nosig_n = 1'b0;
            acc_n   = '0;
          end else if (acc >= TMO_M1) begin
            nosig_n    = 1'b1;
            state_n    = IDLE;
            acc_n      = '0;
            edge_cnt_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc       <= '0;
      edge_cnt  <= '0;
      OUT_VALUE <= '0;
      OUT_VALID <= 1'b0;
      NO_SIGNAL <= 1'b1;
    end else begin
      acc       <= acc_n;
      edge_cnt  <= edge_cnt_n;
      OUT_VALUE <= value_n;
      OUT_VALID <= valid_n;
      NO_SIGNAL <= nosig_n;
    end
  end

endmodule

// File: tb/tb_period_meas_stage.sv
// Directed bench for period_meas_stage: lock, timeout, period change, EN abort,
// mid-run reset and boundary-on-timeout, with hand-computed expectations.
module tb_period_meas_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        freq_in = 1'b0;
  logic [27:0] out_value;
  logic        out_valid;
  logic        no_signal;

  int checks   = 0;
  int failures = 0;

  int per    = 10;
  int ph     = 0;
  bit osc_on = 1'b0;

  period_meas_stage #(
    .OUT_BITS(28), .EDGE_DIV_BITS(2), .TIMEOUT_CYCLES(200)
  ) dut (
    .CLK(clk), .RESET(rst), .EN(en), .FREQ_IN(freq_in),
    .OUT_VALUE(out_value), .OUT_VALID(out_valid), .NO_SIGNAL(no_signal)
  );

  always #5 clk = ~clk;

  // Oscillator: square wave of 'per' CLK cycles, updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (osc_on) begin
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        freq_in = (ph < per / 2);
      end else begin
        freq_in = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from now until OUT_VALID is seen, bounded by maxc.
  task automatic wait_strobe(input int maxc, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < maxc && !got) begin
      tick(1);
      n++;
      if (out_valid) got = 1'b1;
    end
  endtask

  initial begin
    int n;
    bit got;
    bit saw;

    // Reset state
    tick(3);
    check("rst_value", out_value, 0);
    check("rst_valid", out_valid, 0);
    check("rst_nosig", no_signal, 1);
    rst = 1'b0;
    tick(2);
    check("idle_nosig", no_signal, 1);
    check("idle_valid", out_valid, 0);

    // 1. Lock on period 10
    en = 1'b1; ph = per - 1; osc_on = 1'b1;
    wait_strobe(200, n, got);
    check("lock_got", got, 1);
    check("lock_value", out_value, 40);
    check("lock_nosig", no_signal, 0);
    wait_strobe(100, n, got);
    check("lock_spacing", n, 40);
    check("lock_value2", out_value, 40);

    // 3. Oscillator stops right after a strobe
    osc_on = 1'b0;
    n = 0; saw = 1'b0;
    while (n < 300 && !no_signal) begin
      tick(1);
      n++;
      if (out_valid) saw = 1'b1;
    end
    check("tmo_latency", n, 200);
    check("tmo_no_strobe", saw, 0);
    check("tmo_value_held", out_value, 40);
    ph = per - 1; osc_on = 1'b1;
    wait_strobe(200, n, got);
    check("restore_got", got, 1);
    check("restore_value", out_value, 40);
    check("restore_nosig", no_signal, 0);

    // 2. Period 10 -> 13
    per = 13;
    wait_strobe(100, n, got);
    check("p13_trans_got", got, 1);
    check("p13_trans_range", (out_value >= 40 && out_value <= 52), 1);
    wait_strobe(100, n, got);
    check("p13_spacing", n, 52);
    check("p13_value", out_value, 52);
    wait_strobe(100, n, got);
    check("p13_value2", out_value, 52);

    // 4. EN dropped for 5 CLK mid-measurement
    per = 10;
    wait_strobe(100, n, got);
    check("p10_trans_range", (out_value >= 40 && out_value <= 52), 1);
    tick(15);
    en = 1'b0;
    tick(5);
    check("en_drop_nosig", no_signal, 0);
    en = 1'b1;
    wait_strobe(200, n, got);
    check("en_reentry_got", got, 1);
    check("en_reentry_full", (n >= 40), 1);
    check("en_reentry_value", out_value, 40);

    // 5. RESET pulse mid-measurement
    tick(15);
    rst = 1'b1;
    tick(1);
    check("midrst_value", out_value, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_nosig", no_signal, 1);
    rst = 1'b0;
    wait_strobe(200, n, got);
    check("postrst_value", out_value, 40);
    check("postrst_nosig", no_signal, 0);

    // 6. Boundary coincides with timeout: period 50, window 200
    en = 1'b0; osc_on = 1'b0;
    tick(3);
    per = 50; ph = per - 1; osc_on = 1'b1; en = 1'b1;
    wait_strobe(400, n, got);
    check("edge_tmo_got", got, 1);
    check("edge_tmo_value", out_value, 200);
    check("edge_tmo_nosig", no_signal, 0);
    tick(1);
    check("no_back2back", out_valid, 0);
    wait_strobe(300, n, got);
    check("edge_tmo_spacing", n, 199);
    check("edge_tmo_value2", out_value, 200);
    check("edge_tmo_nosig2", no_signal, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
